// File: rtl/adder_seq_ctrl_pkg.sv
// Shared constants and FSM encoding for the nibble-serial add/subtract sequencer.
// State codes are fixed: IDLE=0, RUN=1, DONE=2.
package adder_seq_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// Requester-side bundle for the sequencer: start/done handshake, operands, results.
// The current FSM state is also exported for observation.
interface adder_seq_ctrl_if #(
    parameter int W = 16
);
    // Handshake: start is sampled only while busy=0 (IDLE or DONE). An accepted
    // start captures op_a/op_b/cin/sub. done pulses for one cycle when sum/cout/ovf
    // have just been updated. busy and done are never high together.
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [1:0]   state_dbg;

    modport master (
        output start, op_a, op_b, cin, sub,
        input  busy, done, sum, cout, ovf, state_dbg
    );

    modport slave (
        input  start, op_a, op_b, cin, sub,
        output busy, done, sum, cout, ovf, state_dbg
    );

endinterface

// File: rtl/adder_nibble.sv
// Combinational 4-bit ripple-carry adder: {C4, F} = A + B + C0.
import adder_seq_ctrl_pkg::*;

module adder_nibble (
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                c0,
    output logic [NIBBLE_W-1:0] f,
    output logic                c4
);

    logic [NIBBLE_W:0] c;

    assign c[0] = c0;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        assign f[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign c4 = c[NIBBLE_W];

endmodule

// File: rtl/adder_seq_ctrl.sv
// Wide add/subtract done one nibble per cycle through a single 4-bit adder,
// LSB nibble first, with the inter-nibble carry held in a register.
import adder_seq_ctrl_pkg::*;

module adder_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    adder_seq_ctrl_if.slave  bus
);

    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    state_t                state;
    logic [W-1:0]          a_reg;
    logic [W-1:0]          b_reg;     // already inverted for subtract
    logic [W-1:0]          acc;
    logic                  carry;
    logic [IW-1:0]         idx;
    logic                  busy_q;
    logic                  done_q;
    logic [W-1:0]          sum_q;
    logic                  cout_q;
    logic                  ovf_q;

    logic [NIBBLE_W-1:0]   a_nib;
    logic [NIBBLE_W-1:0]   b_nib;
    logic [NIBBLE_W-1:0]   f_nib;
    logic                  c4;
    logic [W-1:0]          acc_next;
    logic                  accept;

    assign a_nib = a_reg[idx*NIBBLE_W +: NIBBLE_W];
    assign b_nib = b_reg[idx*NIBBLE_W +: NIBBLE_W];

    adder_nibble u_nibble (
        .a  (a_nib),
        .b  (b_nib),
        .c0 (carry),
        .f  (f_nib),
        .c4 (c4)
    );

    // Accumulator with this cycle's nibble merged in, so the last nibble can be
    // written straight into the result register.
    always_comb begin
        acc_next = acc;
        acc_next[idx*NIBBLE_W +: NIBBLE_W] = f_nib;
    end

    assign accept = bus.start && ((state == S_IDLE) || (state == S_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: ;
                S_RUN: begin
                    acc   <= acc_next;
                    carry <= c4;
                    if (idx == LAST_IDX) begin
                        sum_q  <= acc_next;
                        cout_q <= c4;
                        ovf_q  <= (a_reg[W-1] == b_reg[W-1]) && (f_nib[NIBBLE_W-1] != a_reg[W-1]);
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // A start seen in IDLE or DONE overrides the fall-back to IDLE above.
            if (accept) begin
                a_reg  <= bus.op_a;
                b_reg  <= bus.op_b ^ {W{bus.sub}};
                carry  <= bus.sub | bus.cin;
                acc    <= '0;
                idx    <= '0;
                busy_q <= 1'b1;
                state  <= S_RUN;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.state_dbg = state;

    a_busy_done_excl: assert property (@(posedge clk) disable iff (rst) !(busy_q && done_q));

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl (NIBBLES=4): vector table plus hand-written
// sequences for start-while-busy, back-to-back start and mid-operation reset.
module tb_adder_seq_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 16;
    localparam int LAT     = NIBBLES + 1;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    adder_seq_ctrl_if #(.W(W)) bus ();

    adder_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.cin   = cin;
        bus.sub   = sub;
        bus.start = 1'b1;
    endtask

    // Issue one operation from IDLE and check latency, busy span and results.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub,
                          input logic [W-1:0] es, input logic ec, input logic eo);
        int lat;
        int nbusy;
        logic [W-1:0] exp_sum;
        lat   = 0;
        nbusy = 0;
        @(negedge clk);
        drive(a, b, cin, sub);
        exp_q.push_back(es);
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.busy) nbusy++;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        check({name, " latency"}, lat, LAT);
        check({name, " busy cycles"}, nbusy, NIBBLES);
        exp_sum = exp_q.pop_front();
        check({name, " sum"}, bus.sum, exp_sum);
        check({name, " cout"}, bus.cout, ec);
        check({name, " ovf"}, bus.ovf, eo);
        @(negedge clk);
        check({name, " done single pulse"}, bus.done, 1'b0);
    endtask

    initial begin
        int ndone;
        int first;
        int lat;
        logic [W-1:0] done_sum;

        vecs[0]  = '{"add_basic",     16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1]  = '{"add_carry_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{"add_pos_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3]  = '{"sub_neg",       16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4]  = '{"sub_ovf",       16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5]  = '{"sub_neg_cin1",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[6]  = '{"sub_ovf_cin1",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[7]  = '{"add_cin",       16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[8]  = '{"add_neg_ovf",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[9]  = '{"add_mixed_cin", 16'hABCD, 16'h1111, 1'b1, 1'b0, 16'hBCDF, 1'b0, 1'b0};
        vecs[10] = '{"sub_equal",     16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.cin   = 1'b0;
        bus.sub   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", bus.busy, 1'b0);
        check("reset done", bus.done, 1'b0);
        check("reset sum", bus.sum, 16'h0000);
        check("reset cout", bus.cout, 1'b0);
        check("reset ovf", bus.ovf, 1'b0);
        check("reset state", bus.state_dbg, 2'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   vecs[i].sum, vecs[i].cout, vecs[i].ovf);
        end

        // Start pulses while busy are dropped; operand changes after capture are ignored.
        @(negedge clk);
        drive(16'h1234, 16'h4321, 1'b0, 1'b0);
        @(posedge clk);
        #1 drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
        bus.start = 1'b0;
        ndone    = 0;
        first    = 0;
        done_sum = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.done) begin
                ndone++;
                if (first == 0) begin
                    first    = k;
                    done_sum = bus.sum;
                end
            end
            bus.start = (k == 2) || (k == 3);
        end
        check("busy_start done count", ndone, 1);
        check("busy_start done cycle", first, LAT);
        check("busy_start sum", done_sum, 16'h5555);

        // Start held in the DONE cycle is accepted back-to-back; old result holds meanwhile.
        @(negedge clk);
        drive(16'h1234, 16'h4321, 1'b0, 1'b0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                drive(16'h7FFF, 16'h0001, 1'b0, 1'b0);
                break;
            end
        end
        check("b2b first latency", lat, LAT);
        check("b2b first sum", bus.sum, 16'h5555);
        @(posedge clk);
        #1 bus.start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                break;
            end
            check($sformatf("b2b busy k%0d", k), bus.busy, 1'b1);
            check($sformatf("b2b sum hold k%0d", k), bus.sum, 16'h5555);
        end
        check("b2b second latency", lat, LAT);
        check("b2b second sum", bus.sum, 16'h8000);
        check("b2b second cout", bus.cout, 1'b0);
        check("b2b second ovf", bus.ovf, 1'b1);

        // Reset in the middle of an operation discards it.
        @(negedge clk);
        drive(16'h0F0F, 16'h0101, 1'b0, 1'b0);
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst busy", bus.busy, 1'b0);
        check("midrst done", bus.done, 1'b0);
        check("midrst sum", bus.sum, 16'h0000);
        check("midrst cout", bus.cout, 1'b0);
        check("midrst ovf", bus.ovf, 1'b0);
        check("midrst state", bus.state_dbg, 2'd0);
        rst   = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("midrst no done", ndone, 0);
        run_op("after_rst", 16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
